// File: rtl/spi_pkg.sv
// spi_pkg: shared FSM states, width derivation and config field layout for the SPI block
package spi_pkg;
    typedef enum logic [2:0] {IDLE, CONFIG, START, WAIT, DONE} state_t;
    function automatic int cfg_w(input int log_w);
        return log_w + 2;
    endfunction
    function automatic int data_w(input int log_w);
        return 1 << log_w;
    endfunction
    // config word: [log_w-1:0] width, [log_w] CPHA, [log_w+1] CPOL
    function automatic int cpha_bit(input int log_w);
        return log_w;
    endfunction
    function automatic int cpol_bit(input int log_w);
        return log_w + 1;
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting after last_id
module rr_arbiter #(
    parameter int REQ_NUM  = 4,
    parameter int REQ_ID_W = 2
) (
    input  logic [REQ_NUM-1:0]  req_valid,
    input  logic [REQ_ID_W-1:0] last_id,
    output logic                found,
    output logic [REQ_ID_W-1:0] winner,
    output logic [REQ_NUM-1:0]  grant
);
    logic                hi_found;
    logic [REQ_ID_W-1:0] hi_id;
    logic [REQ_ID_W-1:0] lo_id;
    always_comb begin
        hi_found = 1'b0;
        hi_id    = '0;
        lo_id    = '0;
        // descending scan leaves the lowest index above last_id in hi_id, lowest overall in lo_id
        for (int i = REQ_NUM - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                lo_id = REQ_ID_W'(i);
                if (REQ_ID_W'(i) > last_id) begin
                    hi_id    = REQ_ID_W'(i);
                    hi_found = 1'b1;
                end
            end
        end
        found  = |req_valid;
        winner = hi_found ? hi_id : lo_id;
        grant  = found ? (REQ_NUM'(1) << winner) : '0;
    end
endmodule

// File: rtl/spi_arbiter.sv
// spi_arbiter: round-robin sharing of one SPI master with a cached config word
module spi_arbiter
    import spi_pkg::*;
#(
    parameter  int SPI_MAX_WIDTH_LOG = 4,
    parameter  int REQ_NUM           = 4,
    parameter  int REQ_ID_W          = 2,
    localparam int CW                = cfg_w(SPI_MAX_WIDTH_LOG),
    localparam int DW                = data_w(SPI_MAX_WIDTH_LOG)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REQ_NUM-1:0]    req_valid,
    input  logic [REQ_NUM*CW-1:0] req_cfg,
    input  logic [REQ_NUM*DW-1:0] req_din,
    output logic [REQ_NUM-1:0]    req_grant,
    output logic [REQ_NUM-1:0]    resp_done,
    output logic [DW-1:0]         resp_data,
    output logic                  busy,
    output logic                  spi_config_req,
    output logic [CW-1:0]         spi_config_data,
    output logic                  spi_start,
    output logic [DW-1:0]         spi_din,
    input  logic                  spi_finish,
    input  logic [DW-1:0]         spi_dout
);
    state_t              state, state_d;
    logic [REQ_ID_W-1:0] last_id;
    logic [REQ_NUM-1:0]  owner;
    logic [CW-1:0]       lat_cfg, cfg_last;
    logic [DW-1:0]       lat_din, resp_data_q;
    logic                cfg_valid;
    logic                found;
    logic [REQ_ID_W-1:0] win_id;
    logic [REQ_NUM-1:0]  win_grant;
    logic [CW-1:0]       cand_cfg;
    logic [DW-1:0]       cand_din;

    rr_arbiter #(.REQ_NUM(REQ_NUM), .REQ_ID_W(REQ_ID_W)) u_rr (
        .req_valid(req_valid),
        .last_id  (last_id),
        .found    (found),
        .winner   (win_id),
        .grant    (win_grant)
    );

    assign cand_cfg = req_cfg[win_id*CW +: CW];
    assign cand_din = req_din[win_id*DW +: DW];

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    state_d = !found ? IDLE : (cfg_valid && cand_cfg == cfg_last) ? START : CONFIG;
            CONFIG:  state_d = START;
            START:   state_d = WAIT;
            WAIT:    state_d = spi_finish ? DONE : WAIT;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            last_id     <= REQ_ID_W'(REQ_NUM - 1);
            owner       <= '0;
            lat_cfg     <= '0;
            lat_din     <= '0;
            cfg_last    <= '0;
            cfg_valid   <= 1'b0;
            resp_data_q <= '0;
        end else begin
            state <= state_d;
            if (state == IDLE && found) begin
                last_id <= win_id;
                owner   <= win_grant;
                lat_cfg <= cand_cfg;
                lat_din <= cand_din;
            end
            if (state == CONFIG) begin
                cfg_last  <= lat_cfg;
                cfg_valid <= 1'b1;
            end
            if (state == WAIT && spi_finish) resp_data_q <= spi_dout;
            if (state == DONE) owner <= '0;
        end
    end

    assign req_grant       = owner;
    assign resp_done       = (state == DONE) ? owner : '0;
    assign resp_data       = resp_data_q;
    assign busy            = state != IDLE;
    assign spi_config_req  = state == CONFIG;
    assign spi_config_data = lat_cfg;
    assign spi_start       = state == START;
    assign spi_din         = lat_din;
endmodule

// File: tb/tb_spi_arbiter.sv
// tb_spi_arbiter: directed vectors for spi_arbiter with a hand-driven SPI master
module tb_spi_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [23:0] req_cfg = '0;
    logic [63:0] req_din = '0;
    logic [3:0]  req_grant, resp_done;
    logic [15:0] resp_data, spi_din;
    logic        busy, spi_config_req, spi_start;
    logic [5:0]  spi_config_data;
    logic        spi_finish = 1'b0;
    logic [15:0] spi_dout = '0;
    int          total = 0;
    int          bad = 0;
    logic [5:0]  m_last = '0;
    bit          m_valid = 1'b0;

    spi_arbiter #(.SPI_MAX_WIDTH_LOG(4), .REQ_NUM(4), .REQ_ID_W(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_cfg        (req_cfg),
        .req_din        (req_din),
        .req_grant      (req_grant),
        .resp_done      (resp_done),
        .resp_data      (resp_data),
        .busy           (busy),
        .spi_config_req (spi_config_req),
        .spi_config_data(spi_config_data),
        .spi_start      (spi_start),
        .spi_din        (spi_din),
        .spi_finish     (spi_finish),
        .spi_dout       (spi_dout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [5:0] c, input logic [15:0] d);
        req_cfg[i*6 +: 6]  = c;
        req_din[i*16 +: 16] = d;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_grant"}, req_grant, 0);
        check({tag, "_done"}, resp_done, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_creq"}, spi_config_req, 0);
        check({tag, "_start"}, spi_start, 0);
    endtask

    // starts from the IDLE cycle in which the request is already visible
    task automatic txn(input int id, input logic [5:0] cfg, input logic [15:0] din,
                       input logic [15:0] dout, input logic [3:0] drop,
                       input bit fin_start, input bit mess);
        bit         wr;
        logic [3:0] g;
        wr = !m_valid || cfg != m_last;
        g  = 4'b1 << id;
        tick();
        if (wr) begin
            check("cfg_req", spi_config_req, 1);
            check("cfg_data", spi_config_data, cfg);
            check("cfg_start_off", spi_start, 0);
            check("cfg_grant", req_grant, g);
            m_last  = cfg;
            m_valid = 1'b1;
            tick();
        end
        check("start", spi_start, 1);
        check("start_creq_off", spi_config_req, 0);
        check("start_din", spi_din, din);
        check("start_grant", req_grant, g);
        if (fin_start) begin
            spi_finish = 1'b1;
            spi_dout   = 16'hBAD0;
        end
        tick();
        spi_finish = 1'b0;
        check("wait_busy", busy, 1);
        check("wait_done", resp_done, 0);
        check("wait_start_off", spi_start, 0);
        if (mess) begin
            req_din[2*16 +: 16] = 16'hDEAD;
            req_cfg[2*6 +: 6]   = 6'h3F;
        end
        tick();
        check("hold_din", spi_din, din);
        check("hold_cfg", spi_config_data, cfg);
        check("hold_done", resp_done, 0);
        check("hold_grant", req_grant, g);
        spi_finish = 1'b1;
        spi_dout   = dout;
        tick();
        spi_finish = 1'b0;
        check("done", resp_done, g);
        check("rdata", resp_data, dout);
        check("done_grant", req_grant, g);
        req_valid &= ~drop;
        tick();
        check("idle_busy", busy, 0);
        check("idle_done", resp_done, 0);
        check("idle_grant", req_grant, 0);
        check("rdata_hold", resp_data, dout);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("rst");
        check("rst_rdata", resp_data, 0);
        check("rst_cdata", spi_config_data, 0);
        check("rst_din", spi_din, 0);
        @(negedge clk);
        rst_n = 1'b1;

        set_req(0, 6'h15, 16'hA5A5);
        req_valid = 4'b0001;
        txn(0, 6'h15, 16'hA5A5, 16'h3C3C, 4'b0001, 1'b0, 1'b0);

        set_req(0, 6'h15, 16'h1111);
        req_valid = 4'b0001;
        txn(0, 6'h15, 16'h1111, 16'h0F0F, 4'b0001, 1'b1, 1'b0);

        set_req(0, 6'h26, 16'h2222);
        req_valid = 4'b0001;
        txn(0, 6'h26, 16'h2222, 16'hF00D, 4'b0001, 1'b0, 1'b0);

        set_req(3, 6'h26, 16'h3333);
        req_valid = 4'b1000;
        txn(3, 6'h26, 16'h3333, 16'h4444, 4'b1000, 1'b0, 1'b0);

        set_req(0, 6'h26, 16'h1000);
        set_req(1, 6'h26, 16'h2001);
        set_req(2, 6'h26, 16'h3002);
        set_req(3, 6'h26, 16'h4003);
        req_valid = 4'b1111;
        txn(0, 6'h26, 16'h1000, 16'h0A00, 4'b0000, 1'b0, 1'b0);
        txn(1, 6'h26, 16'h2001, 16'h0A01, 4'b0000, 1'b0, 1'b0);
        txn(2, 6'h26, 16'h3002, 16'h0A02, 4'b0000, 1'b0, 1'b1);
        txn(3, 6'h26, 16'h4003, 16'h0A03, 4'b0000, 1'b0, 1'b0);
        txn(0, 6'h26, 16'h1000, 16'h0A04, 4'b1111, 1'b0, 1'b0);
        set_req(2, 6'h26, 16'h3002);

        spi_finish = 1'b1;
        spi_dout   = 16'hEEEE;
        tick();
        spi_finish = 1'b0;
        check_idle_outputs("idle_fin");
        check("idle_fin_rdata", resp_data, 16'h0A04);
        tick();
        check_idle_outputs("idle_fin2");

        set_req(1, 6'h26, 16'h7777);
        req_valid = 4'b0010;
        tick();
        check("rw_start", spi_start, 1);
        check("rw_grant", req_grant, 4'b0010);
        tick();
        check("rw_wait", busy, 1);
        req_valid = 4'b0000;
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("mid_rst");
        check("mid_rst_rdata", resp_data, 0);
        check("mid_rst_din", spi_din, 0);
        @(negedge clk);
        rst_n   = 1'b1;
        m_valid = 1'b0;
        tick();
        check_idle_outputs("post_rst");

        set_req(1, 6'h26, 16'h8888);
        req_valid = 4'b0010;
        txn(1, 6'h26, 16'h8888, 16'h5A5A, 4'b0010, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/spi_arbiter.md
Name: spi_arbiter

Overview:
Shares one SPI master (spi_interface, with its spi_config and sck_gen) between REQ_NUM requesters using round-robin arbitration.
For each granted request it reprograms the master's config (CPOL/CPHA/width word) only when that word differs from the one last written. It then starts the transfer, waits for spi_finish, and returns the received word to the owning requester.
It sits directly above spi_interface and drives that block's config_req/config_data/spi_start/din.

Parameters:
SPI_MAX_WIDTH_LOG, 4, log2 of the max SPI word width. Data width DW = 2**SPI_MAX_WIDTH_LOG. Config width CW = SPI_MAX_WIDTH_LOG+2.
REQ_NUM, 4, number of requesters (2..16).
REQ_ID_W, 2, width of the requester index; must be at least clog2(REQ_NUM).

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous reset, active low
req_valid  in  REQ_NUM  per-requester request level
req_cfg  in  REQ_NUM*CW  per-requester config word; slice i = bits [i*CW +: CW]
req_din  in  REQ_NUM*DW  per-requester transmit word; slice i = bits [i*DW +: DW]
req_grant  out  REQ_NUM  one-hot; owner of the current transaction, held from CONFIG/START through DONE
resp_done  out  REQ_NUM  one-cycle one-hot pulse: transaction of requester i complete
resp_data  out  DW  received word; valid with resp_done, held until the next completion
busy  out  1  high in every state except IDLE
spi_config_req  out  1  to spi_interface config_req
spi_config_data  out  CW  to spi_interface config_data
spi_start  out  1  to spi_interface spi_start
spi_din  out  DW  to spi_interface din
spi_finish  in  1  from spi_interface spi_finish
spi_dout  in  DW  from spi_interface dout

Behaviour:
- Reset values:
  - All outputs are 0; state = IDLE.
  - Round-robin pointer last_id = REQ_NUM-1, so requester 0 has first priority.
  - cfg_valid = 0; cfg_last = 0.
- Arbitration (IDLE only):
  - If any req_valid bit is set, pick the first set bit searching last_id+1, last_id+2, … modulo REQ_NUM.
  - On that cycle, latch the winner id, req_cfg slice and req_din slice.
  - Set last_id = winner and assert req_grant[winner].
  - req_valid, req_cfg and req_din are ignored outside IDLE; changes after the grant do not affect the running transaction.
- FSM transitions:
  - IDLE -> CONFIG when a request wins and (!cfg_valid or latched cfg != cfg_last).
  - IDLE -> START when a request wins and the latched cfg equals cfg_last with cfg_valid = 1 (config skipped).
  - CONFIG: spi_config_req = 1 for exactly one cycle, spi_config_data = latched cfg. Update cfg_last and set cfg_valid = 1. Then go to START.
  - START: spi_start = 1 for exactly one cycle, spi_din = latched din (spi_din is held stable through WAIT). Then go to WAIT.
  - WAIT: stay until spi_finish = 1. On that cycle capture spi_dout into resp_data, then go to DONE.
  - DONE: resp_done[owner] = 1 for one cycle, req_grant is cleared at exit, then go to IDLE.
- Latency:
  - Config write required: request seen at cycle 0 -> config_req at cycle 1 -> spi_start at cycle 2.
  - Config skipped: spi_start at cycle 1.
  - resp_done is asserted 1 cycle after spi_finish.
- Request hold rule: a requester keeps req_valid high until it sees resp_done.
  - If req_valid is still high in the IDLE cycle after DONE, it is a new request and is arbitrated normally.
  - Round-robin means other pending requesters win first.
- Back-to-back: minimum one IDLE cycle between transactions.
- Boundary conditions:
  - spi_finish outside WAIT is ignored.
  - spi_finish in the same cycle as spi_start (START state) is ignored.
  - If a single requester is active, it is granted repeatedly.
  - If all requesters are active, grant order is 0,1,2,3,0,…
- Reset mid-transaction: immediate return to IDLE with no resp_done. cfg_valid is cleared, so the next transaction always reprograms config; the SPI master shares rst_n.

Decomposition:
- Shared package/header spi_pkg:
  - FSM state encodings: IDLE, CONFIG, START, WAIT, DONE.
  - CW/DW derivation from SPI_MAX_WIDTH_LOG.
  - Config field positions, identical to those spi_config decodes.
- Sub-module rr_arbiter (REQ_NUM, REQ_ID_W):
  - Combinational round-robin pick from req_valid and last_id.
  - Outputs: found, winner id, one-hot grant.
- FSM, latches and config cache stay in spi_arbiter.

Test Plan:
- Reset, then req_valid=0001, cfg=0x15, din=0xA5A5.
  - Required: config_req pulse at cycle 1 carrying 0x15, spi_start at cycle 2, spi_din=0xA5A5.
  - Model returns 0x3C3C with spi_finish -> resp_done=0001 and resp_data=0x3C3C the next cycle.
- Repeat requester 0 with the same cfg 0x15.
  - Required: no config_req; spi_start at cycle 1.
- Change cfg to 0x26: config_req reasserted with 0x26.
- req_valid=1111 held continuously, all cfg equal.
  - Required: grants 0001, 0010, 0100, 1000, 0001, each with the matching din on spi_din and a matching resp_done.
- Requester 2 changes req_din and req_cfg during WAIT: spi_din/config unchanged; resp_done=0100.
- Assert spi_finish while IDLE and during START: no state change and no resp_done.
- Assert rst_n=0 during WAIT: all outputs 0, no resp_done.
  - Next request with a previously used cfg still issues config_req.
